hit_tracker: RTL and testbench
==============================

HIT_TRACKER -- requirements
Module: hit_tracker

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
  NUM_HOLES, 18, number of holes/switches/LEDs
  DEBOUNCE_DELAY, 2500, consecutive stable cycles required before a switch change is accepted (>=1)
  COMBO_WIDTH, 8, width of the combo counter
  TIME_WIDTH, 16, width of the reaction-time counter
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  mole_positions  in  NUM_HOLES  mole map from game FSM; nonzero = moles up
  switches  in  NUM_HOLES  raw toggle switches, asynchronous to clk
  game_in_progress  in  1  high while a game is running
  LEDs  out  NUM_HOLES  moles still up and not yet hit
  miss  out  1  one-cycle pulse: wrong-hole toggle or moles escaped
  non_full_clear_hit  out  1  one-cycle pulse: hit with moles remaining
  full_clear_hit  out  1  one-cycle pulse: hit that cleared the last mole
  hit_count  out  $clog2(NUM_HOLES+1)  number of moles hit this cycle, valid with hit pulses, else 0
  combo  out  COMBO_WIDTH  consecutive hits since last miss
  reaction_time  out  TIME_WIDTH  cycles from moles-up to latest hit
  reaction_valid  out  1  one-cycle pulse when reaction_time updates

Function
REQ-003 Each switch bit SHALL pass a 2-flop synchroniser, then a per-bit debouncer: the debounced bit takes the synchronised value on the DEBOUNCE_DELAY-th consecutive edge at which the two differ; any agreeing cycle clears that bit's count.
REQ-004 A press SHALL be any change of a debounced bit vs. its previous-cycle value (either direction); registered outputs respond one edge later (total DEBOUNCE_DELAY+3 edges from a stable raw change).
REQ-005 FSM states SHALL be IDLE, WAIT (game running, moles down) and UP (moles up); IDLE->WAIT when game_in_progress=1; WAIT->UP when mole_positions!=0; UP->WAIT when mole_positions==0; any state->IDLE when game_in_progress=0.
REQ-006 On WAIT->UP, next LEDs SHALL load mole_positions; later changes of a nonzero mole_positions while in UP SHALL be ignored.
REQ-007 On UP->WAIT, if LEDs!=0 the block SHALL pulse miss; LEDs SHALL clear.
REQ-008 Per hole with a press: LED bit set -> hit, clear that bit; bit clear -> miss; evaluation SHALL use post-load/post-clear LEDs of the same cycle (press on load cycle can hit; press on escape cycle is a miss).
REQ-009 hit_count SHALL equal the number of holes hit in the cycle; if >0, full_clear_hit=1 when resulting LEDs==0, else non_full_clear_hit=1; never both.
REQ-010 miss and a hit pulse MAY assert in the same cycle (multi-hole toggle).
REQ-011 combo SHALL add hit_count each hit cycle, saturating at all-ones; any miss cycle SHALL set combo to 0 (miss takes priority over a simultaneous hit).
REQ-012 A reaction counter SHALL clear on WAIT->UP, increment each UP cycle, saturate at all-ones; on a hit cycle reaction_time SHALL latch the counter value and reaction_valid pulse; reaction_time SHALL hold otherwise.
REQ-013 In IDLE: LEDs, pulses and hit_count SHALL be 0, combo SHALL clear, reaction_time SHALL hold; debounce and previous-switch tracking SHALL keep running so toggles made in IDLE never register after game start.

Reset
REQ-014 rst_n low SHALL asynchronously force state IDLE, all outputs, counters, synchroniser and debounced/previous switch registers to 0; release is sampled on clk.
REQ-015 Reset mid-game SHALL discard LEDs and combo; the first cycle after release behaves as IDLE.

Verification (NUM_HOLES=4, DEBOUNCE_DELAY=4, COMBO_WIDTH=3, TIME_WIDTH=4)
REQ-016 game=1, mole_positions=4'b0101, toggle sw0 stable -> 7 edges later non_full_clear_hit=1, hit_count=1, LEDs=0101->0100, combo=1, reaction_valid=1.
REQ-017 Then toggle sw2 -> full_clear_hit=1, LEDs=0000, combo=2; toggle sw1 -> miss=1, combo=0.
REQ-018 mole_positions 0011 then 0000 with no press -> miss pulse on escape edge, LEDs=0000; sw0 glitch of 3 cycles -> no response.
REQ-019 LEDs=1111, toggle sw0 and sw1 same cycle -> hit_count=2, non_full_clear_hit=1; LEDs=0011 toggle sw0+sw2 -> hit and miss same cycle, combo=0; 8 single hits -> combo saturates at 7; no hit for 20 UP cycles -> reaction_time=15.
REQ-020 game=0 during UP -> LEDs=0, combo=0 next edge; toggle sw3 in IDLE, then game=1 -> no miss; rst_n low mid-UP -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/hit_tracker.sv
// Whack-a-mole hit tracker: synchronises and debounces the switches, tracks
// which moles are still up, and reports hits, misses, combo and reaction time.
module hit_tracker #(
  parameter int NUM_HOLES      = 18,
  parameter int DEBOUNCE_DELAY = 2500,
  parameter int COMBO_WIDTH    = 8,
  parameter int TIME_WIDTH     = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_HOLES-1:0]               mole_positions,
  input  logic [NUM_HOLES-1:0]               switches,
  input  logic                               game_in_progress,
  output logic [NUM_HOLES-1:0]               LEDs,
  output logic                               miss,
  output logic                               non_full_clear_hit,
  output logic                               full_clear_hit,
  output logic [$clog2(NUM_HOLES+1)-1:0]     hit_count,
  output logic [COMBO_WIDTH-1:0]             combo,
  output logic [TIME_WIDTH-1:0]              reaction_time,
  output logic                               reaction_valid
);

  localparam int HCW = $clog2(NUM_HOLES + 1);
  localparam int DCW = $clog2(DEBOUNCE_DELAY + 1);
  localparam int SW  = COMBO_WIDTH + HCW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_UP} state_t;

  function automatic logic [HCW-1:0] f_popcount(input logic [NUM_HOLES-1:0] v);
    logic [HCW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_HOLES; i++) c = c + HCW'(v[i]);
    return c;
  endfunction

  function automatic logic [COMBO_WIDTH-1:0] f_combo_add(input logic [COMBO_WIDTH-1:0] a,
                                                         input logic [HCW-1:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SW'({COMBO_WIDTH{1'b1}})) return '1;
    return s[COMBO_WIDTH-1:0];
  endfunction

  logic [NUM_HOLES-1:0]   r_sync1, r_sync2, r_db, r_db_prev;
  logic [DCW-1:0]         r_db_cnt [NUM_HOLES];
  state_t                 r_state;
  logic [NUM_HOLES-1:0]   r_leds;
  logic                   r_miss, r_full, r_nonfull, r_rt_valid;
  logic [HCW-1:0]         r_hit_count;
  logic [COMBO_WIDTH-1:0] r_combo;
  logic [TIME_WIDTH-1:0]  r_rt_cnt, r_reaction_time;

  state_t                 w_next_state;
  logic [NUM_HOLES-1:0]   w_press, w_leds_base, w_leds_next, w_hits, w_wrong;
  logic                   w_load, w_escape_miss, w_active, w_miss, w_hit;
  logic [HCW-1:0]         w_hit_cnt;

  // Synchroniser and per-bit debouncer; runs in every state, including IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_db      <= '0;
      r_db_prev <= '0;
      for (int i = 0; i < NUM_HOLES; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1   <= switches;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      for (int i = 0; i < NUM_HOLES; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_db_cnt[i] == DCW'(DEBOUNCE_DELAY - 1)) begin
            r_db[i]     <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_press = r_db ^ r_db_prev;

  // Presses are judged against the LED map as it stands after this cycle's load/escape.
  always_comb begin
    w_next_state  = r_state;
    w_leds_base   = '0;
    w_load        = 1'b0;
    w_escape_miss = 1'b0;
    w_active      = 1'b0;
    if (!game_in_progress) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_next_state = ST_WAIT;
        ST_WAIT: begin
          w_active = 1'b1;
          if (mole_positions != '0) begin
            w_next_state = ST_UP;
            w_load       = 1'b1;
            w_leds_base  = mole_positions;
          end
        end
        ST_UP: begin
          w_active = 1'b1;
          if (mole_positions == '0) begin
            w_next_state  = ST_WAIT;
            w_escape_miss = |r_leds;
          end else begin
            w_leds_base = r_leds;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
    w_hits      = w_active ? (w_press & w_leds_base) : '0;
    w_wrong     = w_active ? (w_press & ~w_leds_base) : '0;
    w_leds_next = w_leds_base & ~w_hits;
    w_hit_cnt   = f_popcount(w_hits);
    w_hit       = (w_hit_cnt != '0);
    w_miss      = w_escape_miss | (|w_wrong);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_leds          <= '0;
      r_miss          <= 1'b0;
      r_full          <= 1'b0;
      r_nonfull       <= 1'b0;
      r_rt_valid      <= 1'b0;
      r_hit_count     <= '0;
      r_combo         <= '0;
      r_rt_cnt        <= '0;
      r_reaction_time <= '0;
    end else begin
      r_state     <= w_next_state;
      r_leds      <= w_leds_next;
      r_miss      <= w_miss;
      r_hit_count <= w_hit_cnt;
      r_full      <= w_hit && (w_leds_next == '0);
      r_nonfull   <= w_hit && (w_leds_next != '0);
      r_rt_valid  <= w_hit;
      if (!w_active || w_miss) r_combo <= '0;
      else if (w_hit)          r_combo <= f_combo_add(r_combo, w_hit_cnt);
      // A hit on the load cycle itself reacts in zero cycles.
      if (w_load)
        r_rt_cnt <= '0;
      else if (w_active && r_state == ST_UP && r_rt_cnt != '1)
        r_rt_cnt <= r_rt_cnt + 1'b1;
      if (w_hit) r_reaction_time <= w_load ? '0 : r_rt_cnt;
    end
  end

  assign LEDs               = r_leds;
  assign miss               = r_miss;
  assign non_full_clear_hit = r_nonfull;
  assign full_clear_hit     = r_full;
  assign hit_count          = r_hit_count;
  assign combo              = r_combo;
  assign reaction_time      = r_reaction_time;
  assign reaction_valid     = r_rt_valid;

endmodule

// File: tb/tb_hit_tracker.sv
// Directed bench for hit_tracker with a small configuration (4 holes, debounce 4).
module tb_hit_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] mole_positions, switches;
  logic       game_in_progress;
  logic [3:0] LEDs;
  logic       miss, non_full_clear_hit, full_clear_hit, reaction_valid;
  logic [2:0] hit_count;
  logic [2:0] combo;
  logic [3:0] reaction_time;

  int n_vec  = 0;
  int n_fail = 0;
  logic seen;

  hit_tracker #(
    .NUM_HOLES(4), .DEBOUNCE_DELAY(4), .COMBO_WIDTH(3), .TIME_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mole_positions(mole_positions), .switches(switches),
    .game_in_progress(game_in_progress), .LEDs(LEDs), .miss(miss),
    .non_full_clear_hit(non_full_clear_hit), .full_clear_hit(full_clear_hit),
    .hit_count(hit_count), .combo(combo), .reaction_time(reaction_time),
    .reaction_valid(reaction_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (miss !== 1'b0 || non_full_clear_hit !== 1'b0 || full_clear_hit !== 1'b0) seen = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0; game_in_progress = 1'b0; mole_positions = 4'b0000; switches = 4'b0000;
    tick(); tick();
    chk("rst_leds", LEDs, 0);
    chk("rst_combo", combo, 0);
    chk("rst_miss", miss, 0);
    chk("rst_hitcnt", hit_count, 0);
    chk("rst_rt", reaction_time, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_leds", LEDs, 0);

    // Single hit with a remaining mole
    game_in_progress = 1'b1; mole_positions = 4'b0101;
    tick();
    chk("wait_leds", LEDs, 4'b0000);
    tick();
    chk("load_leds", LEDs, 4'b0101);
    switches = 4'b0001;
    repeat (6) tick();
    chk("latency_early", non_full_clear_hit, 0);
    tick();
    chk("hit1_nfc", non_full_clear_hit, 1);
    chk("hit1_cnt", hit_count, 1);
    chk("hit1_leds", LEDs, 4'b0100);
    chk("hit1_combo", combo, 1);
    chk("hit1_rv", reaction_valid, 1);
    chk("hit1_rt", reaction_time, 6);
    chk("hit1_miss", miss, 0);
    tick();
    chk("hit1_rv_pulse", reaction_valid, 0);
    chk("hit1_cnt_pulse", hit_count, 0);
    chk("hit1_rt_hold", reaction_time, 6);

    // Clearing hit, then a wrong-hole miss
    switches = 4'b0101;
    repeat (7) tick();
    chk("hit2_full", full_clear_hit, 1);
    chk("hit2_nfc", non_full_clear_hit, 0);
    chk("hit2_leds", LEDs, 4'b0000);
    chk("hit2_combo", combo, 2);
    chk("hit2_rt", reaction_time, 14);
    switches = 4'b0111;
    repeat (7) tick();
    chk("wrong_miss", miss, 1);
    chk("wrong_combo", combo, 0);
    chk("wrong_hitcnt", hit_count, 0);

    // Escapes and glitch rejection
    mole_positions = 4'b0000;
    tick();
    chk("empty_escape", miss, 0);
    mole_positions = 4'b0011;
    tick();
    chk("load2_leds", LEDs, 4'b0011);
    mole_positions = 4'b0000;
    tick();
    chk("escape_miss", miss, 1);
    chk("escape_leds", LEDs, 4'b0000);
    switches = 4'b0110;
    repeat (3) tick();
    switches = 4'b0111;
    seen = 1'b0;
    watch(12);
    chk("glitch_ignored", seen, 0);

    // Double hit, then hit and miss together
    mole_positions = 4'b1111;
    tick();
    chk("load3_leds", LEDs, 4'b1111);
    switches = 4'b0100;
    repeat (7) tick();
    chk("dbl_cnt", hit_count, 2);
    chk("dbl_nfc", non_full_clear_hit, 1);
    chk("dbl_leds", LEDs, 4'b1100);
    chk("dbl_combo", combo, 2);
    chk("dbl_rt", reaction_time, 6);
    mole_positions = 4'b0000;
    tick();
    chk("esc2_miss", miss, 1);
    chk("esc2_combo", combo, 0);
    mole_positions = 4'b0011;
    tick();
    switches = 4'b0001;
    repeat (7) tick();
    chk("hm_cnt", hit_count, 1);
    chk("hm_miss", miss, 1);
    chk("hm_nfc", non_full_clear_hit, 1);
    chk("hm_leds", LEDs, 4'b0010);
    chk("hm_combo", combo, 0);
    mole_positions = 4'b0000;
    tick();
    chk("esc3_miss", miss, 1);

    // Combo saturation over eight single-mole rounds
    for (int k = 1; k <= 8; k++) begin
      mole_positions = 4'b0001;
      tick();
      switches = switches ^ 4'b0001;
      repeat (7) tick();
      chk("sat_full", full_clear_hit, 1);
      chk("sat_combo", combo, (k > 7) ? 7 : k);
      mole_positions = 4'b0000;
      tick();
      chk("sat_noesc", miss, 0);
    end

    // Reaction counter saturation
    mole_positions = 4'b0001;
    tick();
    repeat (20) tick();
    switches = switches ^ 4'b0001;
    repeat (7) tick();
    chk("rt_sat", reaction_time, 15);
    chk("rt_sat_rv", reaction_valid, 1);
    chk("rt_sat_combo", combo, 7);
    mole_positions = 4'b0000;
    tick();

    // Game stop, IDLE toggles, restart
    mole_positions = 4'b0011;
    tick();
    chk("load4_leds", LEDs, 4'b0011);
    game_in_progress = 1'b0;
    tick();
    chk("stop_leds", LEDs, 0);
    chk("stop_combo", combo, 0);
    chk("stop_rt_hold", reaction_time, 15);
    switches = switches ^ 4'b1000;
    seen = 1'b0;
    watch(12);
    game_in_progress = 1'b1;
    watch(10);
    chk("idle_toggle_ignored", seen, 0);
    chk("restart_leds", LEDs, 4'b0011);
    switches = switches ^ 4'b0001;
    repeat (7) tick();
    chk("restart_hit_combo", combo, 1);
    chk("restart_hit_leds", LEDs, 4'b0010);

    // Asynchronous reset mid-game
    rst_n = 1'b0;
    #2;
    chk("arst_leds", LEDs, 0);
    chk("arst_combo", combo, 0);
    chk("arst_rt", reaction_time, 0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", LEDs, 0);
    tick();
    chk("post_rst_load", LEDs, 4'b0011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
